// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared types, constants and commutation tables for the BLDC commutator
package bldc_pkg;

    localparam logic [2:0] SECT_NONE = 3'd7;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_HALL  = 2'b01,
        FC_STALL = 2'b10
    } fault_code_t;

    typedef struct packed {
        logic [2:0] h;
        logic [2:0] l;
    } gate_pat_t;

    function automatic logic [2:0] hall_to_sector(input logic [2:0] hall);
        logic [2:0] s;
        case (hall)
            3'b101:  s = 3'd0;
            3'b100:  s = 3'd1;
            3'b110:  s = 3'd2;
            3'b010:  s = 3'd3;
            3'b011:  s = 3'd4;
            3'b001:  s = 3'd5;
            default: s = SECT_NONE;
        endcase
        return s;
    endfunction

    // Reverse drive uses the same sector table with high and low phases exchanged.
    function automatic gate_pat_t sector_pattern(input logic [2:0] sector, input logic dir);
        gate_pat_t p;
        case (sector)
            3'd0:    p = '{h: 3'b100, l: 3'b010};
            3'd1:    p = '{h: 3'b100, l: 3'b001};
            3'd2:    p = '{h: 3'b010, l: 3'b001};
            3'd3:    p = '{h: 3'b010, l: 3'b100};
            3'd4:    p = '{h: 3'b001, l: 3'b100};
            3'd5:    p = '{h: 3'b001, l: 3'b010};
            default: p = '{h: 3'b000, l: 3'b000};
        endcase
        if (dir) begin
            p = '{h: p.l, l: p.h};
        end
        return p;
    endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// rtl/bldc_commutator_if.sv - control, sensor and gate-drive bundle of the BLDC commutator
interface bldc_commutator_if;
    logic       EN;
    logic       DIR;
    logic       PWM;
    logic [2:0] HALL;
    logic [2:0] GATE_H;
    logic [2:0] GATE_L;
    logic [2:0] SECTOR;
    logic       FAULT;
    logic [1:0] FAULT_CODE;

    modport master (
        output EN, DIR, PWM, HALL,
        input  GATE_H, GATE_L, SECTOR, FAULT, FAULT_CODE
    );

    modport slave (
        input  EN, DIR, PWM, HALL,
        output GATE_H, GATE_L, SECTOR, FAULT, FAULT_CODE
    );
endinterface

// File: rtl/hall_filter.sv
// rtl/hall_filter.sv - Hall input synchroniser and stability filter
module hall_filter #(
    parameter int FILT_CYC = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] HALL,
    output logic [2:0] HALL_F,
    output logic       HALL_F_VALID_CHG
);

    localparam logic [3:0] FILT_N = 4'(FILT_CYC);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] cand;
    logic [3:0] stable_cnt;
    logic       primed;

    // The first acceptance after reset pulses even when it equals the reset code,
    // so a sensor stuck at 000 is still reported.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1            <= 3'b000;
            sync2            <= 3'b000;
            cand             <= 3'b000;
            stable_cnt       <= 4'd0;
            primed           <= 1'b0;
            HALL_F           <= 3'b000;
            HALL_F_VALID_CHG <= 1'b0;
        end else begin
            sync1            <= HALL;
            sync2            <= sync1;
            HALL_F_VALID_CHG <= 1'b0;
            if (sync2 != cand) begin
                cand       <= sync2;
                stable_cnt <= 4'd1;
            end else if (stable_cnt < FILT_N) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
            if (stable_cnt == FILT_N && (cand != HALL_F || !primed)) begin
                HALL_F           <= cand;
                HALL_F_VALID_CHG <= 1'b1;
                primed           <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step commutation with dead-time blanking and latched faults
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DEAD_CYC  = 4,
    parameter int FILT_CYC  = 3,
    parameter int STALL_W   = 16,
    parameter int STALL_CYC = 50000
) (
    input  logic               CLK,
    input  logic               RST_N,
    bldc_commutator_if.slave   bus
);

    localparam logic [7:0]         DEAD_N    = 8'(DEAD_CYC);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYC);

    logic [2:0]         hall_f;
    logic               hall_chg;
    logic               en_q;
    logic               pwm_q;
    logic               hall_seen;
    gate_pat_t          tgt_q;
    logic [7:0]         blank_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               fault_q;
    fault_code_t        fault_code_q;
    logic [2:0]         gate_h_q;
    logic [2:0]         gate_l_q;
    logic [2:0]         sector_q;

    logic [2:0]         sector_w;
    gate_pat_t          tgt;
    logic               pat_change;
    logic [7:0]         blank_n;
    logic               hall_bad;
    logic               stall_clr;
    logic [STALL_W-1:0] stall_inc;
    logic               stall_hit;
    logic [STALL_W-1:0] stall_n;
    logic               fault_n;
    fault_code_t        fault_code_n;
    logic               drive;

    hall_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_hall_filter (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .HALL             (bus.HALL),
        .HALL_F           (hall_f),
        .HALL_F_VALID_CHG (hall_chg)
    );

    assign sector_w   = hall_to_sector(hall_f);
    assign tgt        = sector_pattern(sector_w, bus.DIR);
    assign pat_change = (tgt != tgt_q) || (bus.EN && !en_q);
    assign blank_n    = pat_change ? DEAD_N :
                        (blank_cnt != 8'd0) ? blank_cnt - 8'd1 : 8'd0;

    // hall_chg covers the cycle in which the first accepted code arrives.
    assign hall_bad  = (hall_seen || hall_chg) && (sector_w == SECT_NONE);
    assign stall_clr = !bus.EN || hall_chg;
    assign stall_inc = stall_cnt + 1'b1;
    assign stall_hit = !stall_clr && !fault_q && (stall_inc == STALL_LIM);

    always_comb begin
        stall_n = stall_cnt;
        if (stall_clr) begin
            stall_n = '0;
        end else if (!fault_q && stall_cnt != STALL_LIM) begin
            stall_n = stall_inc;
        end
    end

    always_comb begin
        fault_n      = fault_q;
        fault_code_n = fault_code_q;
        if (!bus.EN) begin
            fault_n      = 1'b0;
            fault_code_n = FC_NONE;
        end else if (!fault_q) begin
            if (hall_bad) begin
                fault_n      = 1'b1;
                fault_code_n = FC_HALL;
            end else if (stall_hit) begin
                fault_n      = 1'b1;
                fault_code_n = FC_STALL;
            end
        end
    end

    assign drive = bus.EN && !fault_n && (blank_n == 8'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            en_q         <= 1'b0;
            pwm_q        <= 1'b0;
            hall_seen    <= 1'b0;
            tgt_q        <= '0;
            blank_cnt    <= 8'd0;
            stall_cnt    <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            gate_h_q     <= 3'b000;
            gate_l_q     <= 3'b000;
            sector_q     <= SECT_NONE;
        end else begin
            en_q         <= bus.EN;
            pwm_q        <= bus.PWM;
            hall_seen    <= hall_seen || hall_chg;
            tgt_q        <= tgt;
            blank_cnt    <= blank_n;
            stall_cnt    <= stall_n;
            fault_q      <= fault_n;
            fault_code_q <= fault_code_n;
            gate_h_q     <= tgt.h & {3{drive && pwm_q}};
            gate_l_q     <= tgt.l & {3{drive}};
            sector_q     <= sector_w;
        end
    end

    assign bus.GATE_H     = gate_h_q;
    assign bus.GATE_L     = gate_l_q;
    assign bus.SECTOR     = sector_q;
    assign bus.FAULT      = fault_q;
    assign bus.FAULT_CODE = fault_code_q;

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Downstream stage of the PWM generator in the BLDC controller.
- Consumes the single-bit PWM stream plus the three Hall sensor inputs and drives the six inverter gate signals.
- Provides six-step commutation, Hall synchronisation/debounce, dead-time blanking at every commutation, and latched fault detection (invalid Hall code, rotor stall).

Parameters:
- DEAD_CYC, 4: all-gates-off cycles inserted on every change of commanded gate pattern; legal range 1..255.
- FILT_CYC, 3: consecutive cycles a synchronised Hall code must be stable before acceptance; legal range 1..15.
- STALL_W, 16: width of the stall watchdog counter.
- STALL_CYC, 50000: cycles without an accepted sector change (while enabled) before a stall fault; must be < 2^STALL_W.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  drive enable; low forces all gates off and clears faults
- DIR  in  1  0 = forward, 1 = reverse
- PWM  in  1  PWM stream from the PWM generator stage, registered once internally
- HALL  in  3  raw Hall sensors {Ha,Hb,Hc}, asynchronous to CLK
- GATE_H  out  3  high-side gates {A,B,C}, active high
- GATE_L  out  3  low-side gates {A,B,C}, active high
- SECTOR  out  3  current accepted sector 0..5; 7 = none/invalid
- FAULT  out  1  latched fault flag
- FAULT_CODE  out  2  00 none, 01 invalid Hall, 10 stall

Behaviour:
- Reset (RST_N low, async): GATE_H=GATE_L=0, SECTOR=7, FAULT=0, FAULT_CODE=00; sync/filter registers, blank and stall counters cleared; accepted Hall = 000 (invalid).
- Hall path: 2-flop synchroniser, then filter. A candidate code is accepted once it has been identical for FILT_CYC consecutive cycles; any change restarts the count.
- Sector map (accepted Hall -> sector): 101->0, 100->1, 110->2, 010->3, 011->4, 001->5. Codes 000 and 111 are invalid.
- Target pattern, DIR=0 (high phase / low phase):
  - S0: A/B
  - S1: A/C
  - S2: B/C
  - S3: B/A
  - S4: C/A
  - S5: C/B
- DIR=1: high and low phase assignments swap for the same sector.
- Outputs (all registered):
  - GATE_H = target_H & pwm_q & ~blanking & ~FAULT & EN_q
  - GATE_L = target_L & ~blanking & ~FAULT & EN_q
  - The low side is held on, not PWM-chopped.
  - GATE_H[i] and GATE_L[i] are never 1 in the same cycle, under any input.
- Dead-time:
  - Any change in the target pattern (sector change, DIR toggle, EN rising) loads the blank counter with DEAD_CYC. Gates are forced off while it is non-zero.
  - A further change during blanking reloads the counter; there is no accumulation and no intermediate pattern.
  - PWM toggling never triggers blanking.
- Latency: a HALL pin change held stable makes the gates go all-off exactly 2+FILT_CYC+1 cycles after the first sampling edge. The new pattern appears DEAD_CYC cycles after that.
- Invalid Hall fault: accepted code 000 or 111 while EN=1 sets FAULT=1, FAULT_CODE=01, SECTOR=7, gates off next cycle.
- Stall fault:
  - The counter increments each cycle while EN=1 and no fault is present.
  - It clears on every accepted sector change and whenever EN=0.
  - Reaching STALL_CYC sets FAULT=1, FAULT_CODE=10.
- Fault priority and latching:
  - Invalid Hall outranks stall in the same cycle.
  - FAULT is sticky: it stays set regardless of Hall recovery and clears only when EN=0 for ≥1 cycle, or on reset.
- EN=0: gates off next cycle, no dead-time needed. SECTOR keeps tracking the Hall inputs.
- EN rising: blanking of DEAD_CYC cycles before first drive.
- Reset asserted mid-operation: all gates off immediately (asynchronously).

Decomposition:
- Package bldc_pkg:
  - sector encoding constants (SECT_NONE=7)
  - Hall-to-sector function
  - sector/DIR-to-pattern function
  - fault code constants
- Sub-module hall_filter: synchroniser + FILT_CYC debounce. Ports CLK, RST_N, HALL, HALL_F, HALL_F_VALID_CHG (one-cycle pulse on accepted change).

Test Plan:
- Reset, EN=1, PWM=1, HALL=101 held: after 2+3+1 cycles, 4 blank cycles, then GATE_H=100, GATE_L=010, SECTOR=0.
- Sector 0 steady, toggle PWM every cycle: GATE_H[A] follows PWM delayed 2 cycles, GATE_L=010 constant, no blanking.
- Step HALL 101->100: all gates 0 for exactly 4 cycles, then GATE_H=100, GATE_L=001. A 2-cycle glitch to 100 must produce no change.
- Sector 2, DIR 0->1: blank 4 cycles, then GATE_H=001, GATE_L=010. Full forward rotation of 6 sectors never shows H[i]&L[i]=1.
- HALL=111 held: FAULT=1, FAULT_CODE=01, gates 0. HALL back to 101: FAULT stays 1. EN low 1 cycle then high: FAULT=0, drive resumes after blanking.
- STALL_CYC=20, HALL constant: FAULT_CODE=10 on the 20th enabled cycle after the last sector change; RST_N pulsed mid-drive -> gates 0 asynchronously.
